// File: rtl/border_ctrl.sv
// Snake playfield border controller: derives a target wall rectangle from score level and mode,
// then walks the live border toward it one cell per tick without closing a wall onto the head.
module border_ctrl #(
  parameter int unsigned COORD_W     = 4,
  parameter int unsigned SCORE_W     = 8,
  parameter int unsigned X_FULL      = 14,
  parameter int unsigned Y_FULL      = 10,
  parameter int unsigned X_MIN_SPAN  = 8,
  parameter int unsigned Y_MIN_SPAN  = 4,
  parameter int unsigned LEVEL_SCORE = 20,
  parameter int unsigned MAX_LEVEL   = 6,
  parameter int unsigned LVL_W       = 3
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               enable_in,
  input  logic [1:0]         mode,
  input  logic [SCORE_W-1:0] score,
  input  logic               tick,
  input  logic               restart,
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  output logic [COORD_W-1:0] XMAX,
  output logic [COORD_W-1:0] XMIN,
  output logic [COORD_W-1:0] YMAX,
  output logic [COORD_W-1:0] YMIN,
  output logic [LVL_W-1:0]   level,
  output logic               busy,
  output logic               changed
);

  localparam int unsigned CW1 = COORD_W + 1;

  localparam logic [COORD_W:0]   XFullE    = CW1'(X_FULL);
  localparam logic [COORD_W:0]   YFullE    = CW1'(Y_FULL);
  localparam logic [COORD_W:0]   XSpanE    = CW1'(X_MIN_SPAN);
  localparam logic [COORD_W:0]   YSpanE    = CW1'(Y_MIN_SPAN);
  localparam logic [COORD_W:0]   MaxLvlE   = CW1'(MAX_LEVEL);
  localparam logic [COORD_W:0]   XInsetMax = CW1'((X_FULL - X_MIN_SPAN) / 2);
  localparam logic [COORD_W:0]   YInsetMax = CW1'((Y_FULL - Y_MIN_SPAN) / 2);
  localparam logic [COORD_W-1:0] XFullC    = COORD_W'(X_FULL);
  localparam logic [COORD_W-1:0] YFullC    = COORD_W'(Y_FULL);

  logic [SCORE_W-1:0] score_lvl;
  logic [LVL_W-1:0]   level_d, level_q;

  logic [COORD_W:0]   lvl_e, grow_x, grow_y, inset_x, inset_y;
  logic [COORD_W-1:0] tgt_xmin, tgt_xmax, tgt_ymin, tgt_ymax;

  logic [COORD_W-1:0] xmin_d, xmin_q, xmax_d, xmax_q;
  logic [COORD_W-1:0] ymin_d, ymin_q, ymax_d, ymax_q;
  logic               moved_d, moved_q, changed_q;

  always_comb begin
    score_lvl = score / SCORE_W'(LEVEL_SCORE);
    level_d   = (score_lvl > SCORE_W'(MAX_LEVEL)) ? LVL_W'(MAX_LEVEL) : score_lvl[LVL_W-1:0];
  end

  // Target rectangle from the registered level, evaluated one bit wider than a coordinate.
  always_comb begin
    lvl_e   = CW1'(level_q);
    grow_x  = XFullE - (MaxLvlE - lvl_e);
    grow_y  = YFullE - (MaxLvlE - lvl_e);
    inset_x = (lvl_e < XInsetMax) ? lvl_e : XInsetMax;
    inset_y = (lvl_e < YInsetMax) ? lvl_e : YInsetMax;

    tgt_xmin = '0;
    tgt_xmax = XFullC;
    tgt_ymin = '0;
    tgt_ymax = YFullC;
    if (enable_in) begin
      case (mode)
        2'b01: begin
          tgt_xmax = COORD_W'((grow_x < XSpanE) ? XSpanE : grow_x);
          tgt_ymax = COORD_W'((grow_y < YSpanE) ? YSpanE : grow_y);
        end
        2'b10: begin
          tgt_xmin = COORD_W'(inset_x);
          tgt_xmax = COORD_W'(XFullE - inset_x);
          tgt_ymin = COORD_W'(inset_y);
          tgt_ymax = COORD_W'(YFullE - inset_y);
        end
        default: ;
      endcase
    end
  end

  assign busy = (xmin_q != tgt_xmin) || (xmax_q != tgt_xmax) ||
                (ymin_q != tgt_ymin) || (ymax_q != tgt_ymax);

  // Inward steps wait while the head sits on the line that would be removed.
  always_comb begin
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    if (restart) begin
      xmin_d = tgt_xmin;
      xmax_d = tgt_xmax;
      ymin_d = tgt_ymin;
      ymax_d = tgt_ymax;
    end else if (!enable_in) begin
      xmin_d = '0;
      xmax_d = XFullC;
      ymin_d = '0;
      ymax_d = YFullC;
    end else if (tick && busy) begin
      if (xmin_q < tgt_xmin) begin
        if (head_x != xmin_q) xmin_d = xmin_q + 1'b1;
      end else if (xmin_q > tgt_xmin) begin
        xmin_d = xmin_q - 1'b1;
      end

      if (xmax_q > tgt_xmax) begin
        if (head_x != xmax_q) xmax_d = xmax_q - 1'b1;
      end else if (xmax_q < tgt_xmax) begin
        xmax_d = xmax_q + 1'b1;
      end

      if (ymin_q < tgt_ymin) begin
        if (head_y != ymin_q) ymin_d = ymin_q + 1'b1;
      end else if (ymin_q > tgt_ymin) begin
        ymin_d = ymin_q - 1'b1;
      end

      if (ymax_q > tgt_ymax) begin
        if (head_y != ymax_q) ymax_d = ymax_q - 1'b1;
      end else if (ymax_q < tgt_ymax) begin
        ymax_d = ymax_q + 1'b1;
      end
    end
    moved_d = {xmin_d, xmax_d, ymin_d, ymax_d} != {xmin_q, xmax_q, ymin_q, ymax_q};
  end

  // changed reports, one cycle later, that the bounds took a new value at the previous edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      xmin_q    <= '0;
      xmax_q    <= XFullC;
      ymin_q    <= '0;
      ymax_q    <= YFullC;
      level_q   <= '0;
      moved_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      xmin_q    <= xmin_d;
      xmax_q    <= xmax_d;
      ymin_q    <= ymin_d;
      ymax_q    <= ymax_d;
      level_q   <= level_d;
      moved_q   <= moved_d;
      changed_q <= moved_q;
    end
  end

  assign XMIN    = xmin_q;
  assign XMAX    = xmax_q;
  assign YMIN    = ymin_q;
  assign YMAX    = ymax_q;
  assign level   = level_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_border_ctrl.sv
// Bench for border_ctrl: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a rule-level model of the border walk.
module tb_border_ctrl;

  localparam int XF = 14;
  localparam int YF = 10;
  localparam int XS = 8;
  localparam int YS = 4;
  localparam int LS = 20;
  localparam int ML = 6;

  logic       clk = 1'b0;
  logic       nrst, enable_in, tick, restart;
  logic [1:0] mode;
  logic [7:0] score;
  logic [3:0] head_x, head_y;
  logic [3:0] XMAX, XMIN, YMAX, YMIN;
  logic [2:0] level;
  logic       busy, changed;

  int n_checks = 0;
  int n_pass   = 0;

  border_ctrl dut (
    .clk      (clk),
    .nrst     (nrst),
    .enable_in(enable_in),
    .mode     (mode),
    .score    (score),
    .tick     (tick),
    .restart  (restart),
    .head_x   (head_x),
    .head_y   (head_y),
    .XMAX     (XMAX),
    .XMIN     (XMIN),
    .YMAX     (YMAX),
    .YMIN     (YMIN),
    .level    (level),
    .busy     (busy),
    .changed  (changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model state: bounds indexed 0=xmin 1=xmax 2=ymin 3=ymax.
  int m_b[4];
  int m_lvl;
  bit m_mv, m_chg;

  function automatic int full_of(int i);
    return (i == 1) ? XF : (i == 3) ? YF : 0;
  endfunction

  function automatic int tgt_of(int i);
    int fullv, span, inset, g;
    fullv = (i < 2) ? XF : YF;
    span  = (i < 2) ? XS : YS;
    if (!enable_in || mode == 2'd0 || mode == 2'd3) return full_of(i);
    if (mode == 2'd1) begin
      g = fullv - (ML - m_lvl);
      if (g < span) g = span;
      return (i % 2 == 0) ? 0 : g;
    end
    inset = (fullv - span) / 2;
    if (m_lvl < inset) inset = m_lvl;
    return (i % 2 == 0) ? inset : fullv - inset;
  endfunction

  function automatic bit m_busy();
    for (int i = 0; i < 4; i++) if (m_b[i] != tgt_of(i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int next_of(int i);
    int t, c, h;
    bit inward;
    if (restart) return tgt_of(i);
    if (!enable_in) return full_of(i);
    if (!(tick && m_busy())) return m_b[i];
    t = tgt_of(i);
    c = m_b[i];
    h = (i < 2) ? int'(head_x) : int'(head_y);
    if (t == c) return c;
    // A lower bound moving up or an upper bound moving down shrinks the field.
    inward = (i % 2 == 0) ? (t > c) : (t < c);
    if (inward && h == c) return c;
    return (t > c) ? c + 1 : c - 1;
  endfunction

  function automatic bit any_move();
    for (int i = 0; i < 4; i++) if (next_of(i) != m_b[i]) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_b   <= '{0, XF, 0, YF};
      m_lvl <= 0;
      m_mv  <= 1'b0;
      m_chg <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) m_b[i] <= next_of(i);
      m_mv  <= any_move();
      m_chg <= m_mv;
      m_lvl <= (int'(score) / LS > ML) ? ML : int'(score) / LS;
    end
  end

  always @(negedge clk) begin
    chk("xmin", XMIN, m_b[0]);
    chk("xmax", XMAX, m_b[1]);
    chk("ymin", YMIN, m_b[2]);
    chk("ymax", YMAX, m_b[3]);
    chk("level", level, m_lvl);
    chk("busy", busy, m_busy());
    chk("changed", changed, m_chg);
    chk("x_order", int'(XMIN < XMAX), 1);
    chk("y_order", int'(YMIN < YMAX), 1);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_bounds(input string tag, input int xmn, input int xmx, input int ymn,
                            input int ymx);
    chk({tag, "_xmin"}, XMIN, xmn);
    chk({tag, "_xmax"}, XMAX, xmx);
    chk({tag, "_ymin"}, YMIN, ymn);
    chk({tag, "_ymax"}, YMAX, ymx);
  endtask

  initial begin
    nrst = 1'b1; enable_in = 1'b1; mode = 2'd0; score = '0;
    tick = 1'b0; restart = 1'b0; head_x = 4'd7; head_y = 4'd5;
    #1 nrst = 1'b0;
    cyc();
    cyc();
    nrst = 1'b1;

    chk_bounds("rst", 0, 14, 0, 10);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_changed", changed, 0);
    mode = 2'd1;
    #1 chk("grow_busy", busy, 1);

    // Grow at level 0 via restart.
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk_bounds("grow0", 0, 8, 0, 4);
    chk("grow0_busy", busy, 0);
    chk("grow0_chg_early", changed, 0);
    cyc();
    chk("grow0_chg", changed, 1);
    cyc();
    chk("grow0_chg_off", changed, 0);

    // Score 45 -> level 2, two ticks to settle.
    score = 8'd45;
    cyc();
    chk("lvl2", level, 2);
    chk("lvl2_busy", busy, 1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk_bounds("grow_t1", 0, 9, 0, 5);
    cyc();
    chk("grow_t1_chg", changed, 1);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk_bounds("grow_t2", 0, 10, 0, 6);
    chk("grow_t2_busy", busy, 0);

    // Shrink from full field at level 3.
    mode = 2'd0; restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk_bounds("full", 0, 14, 0, 10);
    mode = 2'd2; score = 8'd60; head_x = 4'd7; head_y = 4'd5;
    cyc();
    chk("lvl3", level, 3);
    tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
    chk_bounds("shrink3", 3, 11, 3, 7);
    chk("shrink3_busy", busy, 0);
    score = 8'd200;
    cyc();
    cyc();
    chk("lvl6", level, 6);
    chk_bounds("shrink_clamp", 3, 11, 3, 7);
    chk("shrink_clamp_busy", busy, 0);

    // Head on the left wall defers XMIN only.
    mode = 2'd0; restart = 1'b1;
    cyc();
    restart = 1'b0;
    mode = 2'd2; head_x = 4'd0; head_y = 4'd5; tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk_bounds("defer", 0, 13, 1, 9);
    head_x = 4'd5; tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk_bounds("retry", 1, 12, 2, 8);

    // Dropping enable snaps to full without a tick.
    enable_in = 1'b0;
    cyc();
    enable_in = 1'b1;
    chk_bounds("dis", 0, 14, 0, 10);
    cyc();
    chk("dis_chg", changed, 1);

    // Restart beats a simultaneous tick.
    tick = 1'b1; restart = 1'b1;
    cyc();
    tick = 1'b0; restart = 1'b0;
    chk_bounds("rst_tick", 3, 11, 3, 7);

    // Asynchronous reset mid-walk.
    mode = 2'd0; restart = 1'b1;
    cyc();
    restart = 1'b0;
    mode = 2'd2; head_x = 4'd7; head_y = 4'd5; tick = 1'b1;
    cyc();
    cyc();
    tick = 1'b0;
    chk_bounds("mid", 2, 12, 2, 8);
    #1 nrst = 1'b0;
    #1;
    chk_bounds("arst", 0, 14, 0, 10);
    chk("arst_level", level, 0);
    chk("arst_changed", changed, 0);
    cyc();
    nrst = 1'b1;

    // Randomized traffic, head biased onto the walls to exercise deferral.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(19) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(15) == 0) score = 8'($urandom);
      enable_in = ($urandom_range(29) != 0);
      restart   = ($urandom_range(29) == 0);
      tick      = 1'($urandom_range(1));
      case ($urandom_range(2))
        0:       head_x = 4'(m_b[0]);
        1:       head_x = 4'(m_b[1]);
        default: head_x = 4'($urandom_range(15));
      endcase
      case ($urandom_range(2))
        0:       head_y = 4'(m_b[2]);
        1:       head_y = 4'(m_b[3]);
        default: head_y = 4'($urandom_range(15));
      endcase
      cyc();
    end
    tick = 1'b0; restart = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/border_ctrl.md
Name: border_ctrl

Overview:
- Parametrised playfield-border controller for the snake game.
- Computes target wall coordinates from score and play mode: full, grow or shrink.
- Walks the live border toward that target one cell per game tick. It never closes a wall onto the snake head.
- Feeds XMAX/XMIN/YMAX/YMIN to collision, food placement and the display renderer.

Parameters:
COORD_W, 4, width of each border coordinate and head coordinate
SCORE_W, 8, score width
X_FULL, 14, XMAX of the full field (XMIN of full field is 0)
Y_FULL, 10, YMAX of the full field (YMIN of full field is 0)
X_MIN_SPAN, 8, smallest allowed XMAX-XMIN
Y_MIN_SPAN, 4, smallest allowed YMAX-YMIN
LEVEL_SCORE, 20, score points per level
MAX_LEVEL, 6, level saturation value
LVL_W, 3, level width; must hold MAX_LEVEL

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
enable_in  in  1  border feature on (game_mode == WALL_INCREASE)
mode  in  2  00 full, 01 grow, 10 shrink, 11 treated as full
score  in  SCORE_W  current score
tick  in  1  one-cycle game-step strobe
restart  in  1  synchronous snap of border to current target
head_x  in  COORD_W  snake head column
head_y  in  COORD_W  snake head row
XMAX, XMIN, YMAX, YMIN  out  COORD_W each  registered live border
level  out  LVL_W  registered current level
busy  out  1  live border != target (combinational from registers)
changed  out  1  one-cycle pulse: a bound changed in the previous cycle

Behaviour:
- Clock/reset: one clock clk; nrst asynchronous, active-low.
- Reset values: XMIN=0, XMAX=X_FULL, YMIN=0, YMAX=Y_FULL, level=0, changed=0. busy evaluates combinationally; it is 0 after reset when enable_in=0 or mode=full.
- Level register: level_q <= min(score / LEVEL_SCORE, MAX_LEVEL), updated every cycle. There is 1 cycle of latency from score to level.
- Target, from level_q and mode:
  - Full (00/11), or enable_in=0: 0, X_FULL, 0, Y_FULL.
  - Grow (01): XMIN=YMIN=0; XMAX = max(X_FULL-(MAX_LEVEL-level), X_MIN_SPAN); YMAX = max(Y_FULL-(MAX_LEVEL-level), Y_MIN_SPAN).
  - Shrink (10): xi = min(level, (X_FULL-X_MIN_SPAN)/2); yi = min(level, (Y_FULL-Y_MIN_SPAN)/2). XMIN=xi, XMAX=X_FULL-xi, YMIN=yi, YMAX=Y_FULL-yi.
  - All arithmetic is unsigned in COORD_W+1 bits; the subtraction cannot underflow for legal parameters.
- Update priority per cycle, highest first:
  1. restart=1: all four bounds load the target (computed from current level_q) in one cycle; no head check.
  2. enable_in=0: bounds load the full field immediately; no tick needed.
  3. tick=1 and busy: each bound differing from its target moves exactly one unit toward it. All four bounds evaluate in the same cycle.
  4. Otherwise: hold.
- Inward-move deferral: an inward step is skipped on that tick if the head sits on the line being removed.
  - XMIN+1 is skipped when head_x==XMIN.
  - XMAX-1 is skipped when head_x==XMAX.
  - YMIN+1 is skipped when head_y==YMIN.
  - YMAX-1 is skipped when head_y==YMAX.
  - Outward steps are never deferred. A deferred bound retries on the next tick.
- changed: registered; set for one cycle when any bound register changed value in the previous cycle, by any cause. It is not set when a load writes identical values.
- Target moves mid-walk (score or mode change): stepping simply re-aims at the new target on the next tick. No overshoot; direction may reverse.
- tick and restart in the same cycle: restart wins and the tick is consumed.
- Invariants at all times: XMIN<XMAX and YMIN<YMAX; spans never below X_MIN_SPAN/Y_MIN_SPAN once settled.
- Reset asserted mid-walk returns all outputs to reset values immediately.

Test Plan:
- Reset, enable_in=1, mode=01, score=0, restart pulse -> next cycle XMIN=0,XMAX=8,YMIN=0,YMAX=4, level=0, busy=0, changed=1 one cycle later.
- From the grow/level-0 state, score=45 -> level=2 after 1 cycle. Tick 1 gives XMAX=9,YMAX=5; tick 2 gives XMAX=10,YMAX=6; busy then 0; changed pulses once per tick.
- mode=10 from full field, score=60, head at (7,5), 3 ticks -> XMIN=3,XMAX=11,YMIN=3,YMAX=7. score=200 -> level=6, border unchanged (inset clamped at 3), busy=0.
- Shrink from full with head_x=0: first tick gives XMIN stays 0 while XMAX=13,YMIN=1,YMAX=9. Move head_x to 5 and tick -> XMIN=1.
- Mid-walk in shrink, drop enable_in -> next cycle 0/14/0/10 without tick, changed=1. Raise tick with restart in the same cycle -> restart load only.
- Assert nrst asynchronously between clock edges mid-walk -> outputs immediately 0/14/0/10, level=0, changed=0.
